lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the 1024x32 data memory.
- Accepts byte-addressed RV32 load/store requests over a valid/ready handshake.
- Drives the memory's word address, rw_mode, byte enables and replicated write data.
- Captures the memory's 1-cycle registered read data, aligns and sign/zero-extends it, and returns a response over a valid/ready handshake.

Parameters:
- MEM_AW, 10: memory word-address width; memory spans 4*2^MEM_AW bytes.
- BASE_ADDR, 32'h0000_0000: byte address of memory word 0; must be 4-byte aligned.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- in_req_valid  in  1  request valid.
- out_req_ready  out  1  request accepted when valid&&ready.
- in_req_we  in  1  1=store, 0=load.
- in_req_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- in_req_addr  in  32  byte address.
- in_req_wdata  in  32  store data, LSB-justified.
- out_resp_valid  out  1  response valid.
- in_resp_ready  in  1  response consumed when valid&&ready.
- out_resp_rdata  out  32  extended load data; 0 for stores and errors.
- out_resp_err  out  1  illegal funct3, out-of-range address, or misaligned access (see Optional Feature).
- out_mem_addr  out  MEM_AW  memory word address.
- out_mem_rw_mode  out  1  0=read, 1=write.
- out_mem_write_data  out  32  byte-replicated store data.
- out_mem_byte_en  out  4  byte write enables.
- in_mem_data  in  32  memory read data, valid the cycle after the read edge.

Behaviour:
- Reset values:
  - FSM=IDLE, out_req_ready=1, out_resp_valid=0, out_resp_rdata=0, out_resp_err=0.
  - out_mem_rw_mode=0, out_mem_byte_en=0, out_mem_addr=0, out_mem_write_data=0.
- FSM states: IDLE, ACCESS, CAPTURE, RESP. out_req_ready=1 only in IDLE. All request fields are registered on accept.
- IDLE -> ACCESS on accept of a legal request.
- IDLE -> RESP on accept of an erroring request:
  - err=1, rdata=0, no memory access.
  - Erroring means illegal funct3, or addr outside [BASE_ADDR, BASE_ADDR+4*2^MEM_AW).
  - Illegal funct3: loads 011/110/111; stores anything except 000/001/010.
- ACCESS (one cycle), mem outputs driven from registered request:
  - out_mem_addr = (addr-BASE_ADDR)[MEM_AW+1:2].
  - Store:
    - rw_mode=1.
    - SB: byte_en=4'b0001<<addr[1:0], write_data={4{wdata[7:0]}}.
    - SH: byte_en=4'b0011<<{addr[1],1'b0}, write_data={2{wdata[15:0]}}.
    - SW: byte_en=4'b1111, write_data=wdata.
    - Next state RESP.
  - Load: rw_mode=0, byte_en=0; next state CAPTURE.
- Outside ACCESS: rw_mode=0, byte_en=0; addr and write_data hold last value.
- CAPTURE (loads only):
  - Select the byte/half of in_mem_data by addr[1:0] / addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Register result into out_resp_rdata; go to RESP.
- RESP:
  - out_resp_valid=1; rdata and err held stable until in_resp_ready.
  - On in_resp_ready: return to IDLE. A new request cannot be accepted in the same cycle.
- Latency, accept edge to out_resp_valid:
  - Store: 2 cycles.
  - Load: 3 cycles.
  - Error: 1 cycle.
- Reset mid-operation: returns immediately to IDLE and forces rw_mode=0. A store still in ACCESS when reset asserts is not written. No response is produced for the aborted request.
- Address arithmetic is 32-bit unsigned; the range check uses the full 32 bits, with no wrap.

Optional Feature:
- Macro: LSU_MISALIGN_ERR_EN.
- Defined:
  - Misaligned halfword (addr[0]=1) or word (addr[1:0]!=0) access -> IDLE->RESP with err=1, no memory access.
- Undefined:
  - Misaligned accesses proceed with low offset bits forced to zero: half uses {addr[1],0}; word uses 00.
  - err=0; byte accesses are unaffected either way.

Test Plan:
- Reset: assert i_rst mid-ACCESS of SW -> rw_mode=0 immediately; the target word is unchanged on readback.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10:
  - mem word 4 written with byte_en=1111.
  - Load response rdata=0xDEADBEEF, err=0, 3 cycles after accept.
- SB 0x13 data 0x000000A5 over word 0x11223344 -> byte_en=1000, write_data=0xA5A5A5A5; LW 0x10 returns 0xA5223344.
- Extension on word 0x80F07F01:
  - LB 0x0 -> 0x00000001.
  - LB 0x3 -> 0xFFFFFF80.
  - LBU 0x3 -> 0x00000080.
  - LH 0x2 -> 0xFFFF80F0.
  - LHU 0x2 -> 0x000080F0.
- Errors, each -> err=1, rdata=0, no mem write, 1-cycle latency:
  - funct3=011 load.
  - Store funct3=100.
  - addr=BASE_ADDR+0x1000 with MEM_AW=10.
- Misaligned LW 0x12 with word 4 = 0xDEADBEEF:
  - With LSU_MISALIGN_ERR_EN: err=1.
  - Without: rdata=0xDEADBEEF, err=0.
  - With in_resp_ready held low 5 cycles, the response stays stable and out_req_ready stays 0.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage in front of a 2^MEM_AW x 32 data memory.
// Accepts byte-addressed RV32 loads/stores on a valid/ready request channel,
// drives the memory word address / rw_mode / byte enables / replicated write
// data, captures the 1-cycle registered read data, aligns and extends it, and
// returns {rdata, err} on a valid/ready response channel.
//
// Ports:
//   i_clk, i_rst                        clock, async active-high reset
//   in_req_valid / out_req_ready        request handshake
//   in_req_we, in_req_funct3            store flag, RV32 funct3
//   in_req_addr, in_req_wdata           byte address, LSB-justified store data
//   out_resp_valid / in_resp_ready      response handshake
//   out_resp_rdata, out_resp_err        extended load data, error flag
//   out_mem_addr, out_mem_rw_mode       memory word address, 0=read 1=write
//   out_mem_write_data, out_mem_byte_en byte-replicated data, byte enables
//   in_mem_data                         memory read data (cycle after read edge)
//
// Build option: define LSU_MISALIGN_ERR_EN to report misaligned half/word
// accesses as errors; otherwise the low offset bits are forced to zero.
module lsu_ctrl #(
  parameter int unsigned MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              in_req_valid,
  output logic              out_req_ready,
  input  logic              in_req_we,
  input  logic [2:0]        in_req_funct3,
  input  logic [31:0]       in_req_addr,
  input  logic [31:0]       in_req_wdata,
  output logic              out_resp_valid,
  input  logic              in_resp_ready,
  output logic [31:0]       out_resp_rdata,
  output logic              out_resp_err,
  output logic [MEM_AW-1:0] out_mem_addr,
  output logic              out_mem_rw_mode,
  output logic [31:0]       out_mem_write_data,
  output logic [3:0]        out_mem_byte_en,
  input  logic [31:0]       in_mem_data
);

  localparam logic [32:0] SPAN = 33'(1) << (MEM_AW + 2);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t state_q, state_d;

  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        boff_q, boff_d;
  logic              ready_d, valid_d, err_d, rw_d;
  logic [31:0]       rdata_d, wd_d;
  logic [3:0]        be_d;
  logic [MEM_AW-1:0] maddr_d;

  // Request decode: offset, range, funct3 legality, aligned byte offset.
  logic [31:0] off_c;
  logic        in_range_c, f3_ok_c, bad_c;
  logic [1:0]  boff_c;

  always_comb begin
    off_c      = in_req_addr - BASE_ADDR;
    in_range_c = (in_req_addr >= BASE_ADDR) && ({1'b0, off_c} < SPAN);
    if (in_req_we) f3_ok_c = (in_req_funct3[2] == 1'b0) && (in_req_funct3[1:0] != 2'b11);
    else           f3_ok_c = (in_req_funct3[1:0] != 2'b11) && (in_req_funct3 != 3'b110);
    case (in_req_funct3[1:0])
      2'b00:   boff_c = off_c[1:0];
      2'b01:   boff_c = {off_c[1], 1'b0};
      default: boff_c = 2'b00;
    endcase
`ifdef LSU_MISALIGN_ERR_EN
    bad_c = !in_range_c || !f3_ok_c ||
            ((in_req_funct3[1:0] == 2'b01) && off_c[0]) ||
            ((in_req_funct3[1:0] == 2'b10) && (off_c[1:0] != 2'b00));
`else
    bad_c = !in_range_c || !f3_ok_c;
`endif
  end

  // Load data alignment and extension for the CAPTURE cycle.
  logic [31:0] shifted_c, ext_c;

  always_comb begin
    shifted_c = in_mem_data >> {boff_q, 3'b000};
    case (f3_q)
      3'b000:  ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b100:  ext_c = {24'h0, shifted_c[7:0]};
      3'b001:  ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b101:  ext_c = {16'h0, shifted_c[15:0]};
      default: ext_c = shifted_c;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    boff_d  = boff_q;
    rdata_d = out_resp_rdata;
    err_d   = out_resp_err;
    maddr_d = out_mem_addr;
    wd_d    = out_mem_write_data;
    rw_d    = 1'b0;
    be_d    = 4'b0000;
    case (state_q)
      IDLE: begin
        if (in_req_valid) begin
          we_d    = in_req_we;
          f3_d    = in_req_funct3;
          boff_d  = boff_c;
          rdata_d = 32'h0;
          err_d   = bad_c;
          if (bad_c) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            maddr_d = off_c[MEM_AW+1:2];
            if (in_req_we) begin
              rw_d = 1'b1;
              case (in_req_funct3[1:0])
                2'b00: begin
                  be_d = 4'b0001 << boff_c;
                  wd_d = {4{in_req_wdata[7:0]}};
                end
                2'b01: begin
                  be_d = 4'b0011 << boff_c;
                  wd_d = {2{in_req_wdata[15:0]}};
                end
                default: begin
                  be_d = 4'b1111;
                  wd_d = in_req_wdata;
                end
              endcase
            end
          end
        end
      end
      ACCESS:  state_d = we_q ? RESP : CAPTURE;
      CAPTURE: begin
        rdata_d = ext_c;
        state_d = RESP;
      end
      RESP:    if (in_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == RESP);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q            <= IDLE;
      we_q               <= 1'b0;
      f3_q               <= 3'b000;
      boff_q             <= 2'b00;
      out_req_ready      <= 1'b1;
      out_resp_valid     <= 1'b0;
      out_resp_rdata     <= 32'h0;
      out_resp_err       <= 1'b0;
      out_mem_addr       <= '0;
      out_mem_rw_mode    <= 1'b0;
      out_mem_write_data <= 32'h0;
      out_mem_byte_en    <= 4'b0000;
    end else begin
      state_q            <= state_d;
      we_q               <= we_d;
      f3_q               <= f3_d;
      boff_q             <= boff_d;
      out_req_ready      <= ready_d;
      out_resp_valid     <= valid_d;
      out_resp_rdata     <= rdata_d;
      out_resp_err       <= err_d;
      out_mem_addr       <= maddr_d;
      out_mem_rw_mode    <= rw_d;
      out_mem_write_data <= wd_d;
      out_mem_byte_en    <= be_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: behavioural memory, reference model, directed and
// random requests.
module tb_lsu_ctrl;

  localparam int unsigned MEM_AW = 10;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int unsigned WORDS  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              in_req_valid, in_req_we, in_resp_ready;
  logic [2:0]        in_req_funct3;
  logic [31:0]       in_req_addr, in_req_wdata;
  logic              out_req_ready, out_resp_valid, out_resp_err;
  logic [31:0]       out_resp_rdata;
  logic [MEM_AW-1:0] out_mem_addr;
  logic              out_mem_rw_mode;
  logic [31:0]       out_mem_write_data;
  logic [3:0]        out_mem_byte_en;
  logic [31:0]       in_mem_data;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_ctrl #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
    .in_req_we(in_req_we), .in_req_funct3(in_req_funct3),
    .in_req_addr(in_req_addr), .in_req_wdata(in_req_wdata),
    .out_resp_valid(out_resp_valid), .in_resp_ready(in_resp_ready),
    .out_resp_rdata(out_resp_rdata), .out_resp_err(out_resp_err),
    .out_mem_addr(out_mem_addr), .out_mem_rw_mode(out_mem_rw_mode),
    .out_mem_write_data(out_mem_write_data), .out_mem_byte_en(out_mem_byte_en),
    .in_mem_data(in_mem_data)
  );

  always #5 clk = ~clk;

  // Memory driven by the DUT: byte-enabled write, registered read.
  logic [31:0] mem [WORDS];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < int'(WORDS); i++) mem[i] <= 32'h0;
    end else if (out_mem_rw_mode) begin
      for (int i = 0; i < 4; i++)
        if (out_mem_byte_en[i]) mem[out_mem_addr][8*i +: 8] <= out_mem_write_data[8*i +: 8];
    end
    in_mem_data <= mem[out_mem_addr];
  end

  // Reference memory contents, updated by the model on each legal store.
  logic [31:0] ref_mem [WORDS];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Behavioural model of one request, from the architectural rules.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic err,
                                output logic [31:0] rdata, output logic [3:0] be,
                                output logic [31:0] wd, output int widx, output int lat);
    longint a, off, v;
    int size, nb, bo;
    bit legal, misal;
    a     = longint'(addr);
    size  = int'(f3[1:0]);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misal = (size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0);
    err   = !legal || a < longint'(BASE) || a >= longint'(BASE) + 4 * longint'(WORDS);
`ifdef LSU_MISALIGN_ERR_EN
    err   = err || misal;
`endif
    off   = a - longint'(BASE);
    widx  = int'(off / 4);
    bo    = int'(off % 4);
    if (size == 1) bo = bo - (bo % 2);
    if (size >= 2) bo = 0;
    nb    = 1 << (size > 2 ? 2 : size);
    rdata = 32'h0;
    be    = 4'h0;
    wd    = 32'h0;
    lat   = err ? 1 : (we ? 2 : 3);
    if (err) return;
    if (we) begin
      be = 4'(((1 << nb) - 1) << bo);
      case (size)
        0:       wd = {4{wdata[7:0]}};
        1:       wd = {2{wdata[15:0]}};
        default: wd = wdata;
      endcase
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[widx][8*i +: 8] = wd[8*i +: 8];
    end else begin
      v = longint'(ref_mem[widx]) >> (8 * bo);
      if (nb < 4) begin
        v = v & ((longint'(1) << (8 * nb)) - 1);
        if (!f3[2] && ((v >> (8 * nb - 1)) & 1) == 1) v = v - (longint'(1) << (8 * nb));
      end
      rdata = 32'(v);
    end
  endfunction

  // Issue one request, check every cycle until the response is consumed.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] g_rdata, output logic g_err, output int g_lat,
                        output logic [3:0] g_be, output logic [31:0] g_wd);
    logic        e_err;
    logic [31:0] e_rdata, e_wd;
    logic [3:0]  e_be;
    int          e_widx, e_lat;
    bit          seen;
    model(we, f3, addr, wdata, e_err, e_rdata, e_be, e_wd, e_widx, e_lat);
    @(negedge clk);
    chk("req_ready_idle", 32'(out_req_ready), 32'd1);
    in_req_valid = 1'b1; in_req_we = we; in_req_funct3 = f3;
    in_req_addr = addr; in_req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    in_req_valid = 1'b0;
    g_be = 4'h0; g_wd = 32'h0; g_lat = 99; seen = 0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      if (c == 1) begin
        g_be = out_mem_byte_en; g_wd = out_mem_write_data;
        chk("access_rw_be", {27'h0, out_mem_rw_mode, out_mem_byte_en},
            {27'h0, we && !e_err, e_err ? 4'h0 : e_be});
        if (!e_err) chk("access_addr", 32'(out_mem_addr), 32'(e_widx));
        if (!e_err && we) chk("access_wdata", out_mem_write_data, e_wd);
      end else begin
        chk("idle_rw_be", {27'h0, out_mem_rw_mode, out_mem_byte_en}, 32'h0);
      end
      chk("busy_ready", 32'(out_req_ready), 32'd0);
      if (out_resp_valid) begin
        g_lat = c; seen = 1;
      end else begin
        @(negedge clk);
      end
    end
    chk("latency", 32'(g_lat), 32'(e_lat));
    g_rdata = out_resp_rdata; g_err = out_resp_err;
    chk("resp_rdata", g_rdata, e_rdata);
    chk("resp_err", 32'(g_err), 32'(e_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_stable", {out_resp_rdata[30:0], out_resp_err},
          {g_rdata[30:0], g_err});
      chk("hold_hs", {30'h0, out_resp_valid, out_req_ready}, 32'h2);
    end
    in_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_resp_ready = 1'b0;
    chk("after_resp", {30'h0, out_resp_valid, out_req_ready}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wd;
    logic        er;
    int          lat;
    logic [3:0]  be;
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr;

    i_rst = 1'b1; mem_clr = 1'b1;
    in_req_valid = 1'b0; in_req_we = 1'b0; in_req_funct3 = 3'h0;
    in_req_addr = 32'h0; in_req_wdata = 32'h0; in_resp_ready = 1'b0;
    for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(out_req_ready), 32'd1);
    chk("rst_resp", {out_resp_rdata[30:0], out_resp_valid}, 32'h0);
    chk("rst_err", 32'(out_resp_err), 32'd0);
    chk("rst_mem", {out_mem_write_data[26:0], out_mem_rw_mode, out_mem_byte_en}, 32'h0);
    chk("rst_maddr", 32'(out_mem_addr), 32'h0);
    i_rst = 1'b0; mem_clr = 1'b0;

    // SW then LW at 0x10.
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, be, wd);
    chk("sw_be", 32'(be), 32'hF);
    chk("sw_lat", 32'(lat), 32'd2);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er, lat, be, wd);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_lat", 32'(lat), 32'd3);

    // SB into the high byte.
    do_req(1'b1, 3'd2, 32'h10, 32'h11223344, 0, rd, er, lat, be, wd);
    do_req(1'b1, 3'd0, 32'h13, 32'h000000A5, 1, rd, er, lat, be, wd);
    chk("sb_be", 32'(be), 32'h8);
    chk("sb_wd", wd, 32'hA5A5A5A5);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er, lat, be, wd);
    chk("sb_readback", rd, 32'hA5223344);

    // Extension cases.
    do_req(1'b1, 3'd2, 32'h0, 32'h80F07F01, 0, rd, er, lat, be, wd);
    do_req(1'b0, 3'd0, 32'h0, 32'h0, 0, rd, er, lat, be, wd);
    chk("lb0", rd, 32'h00000001);
    do_req(1'b0, 3'd0, 32'h3, 32'h0, 0, rd, er, lat, be, wd);
    chk("lb3", rd, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'h3, 32'h0, 0, rd, er, lat, be, wd);
    chk("lbu3", rd, 32'h00000080);
    do_req(1'b0, 3'd1, 32'h2, 32'h0, 2, rd, er, lat, be, wd);
    chk("lh2", rd, 32'hFFFF80F0);
    do_req(1'b0, 3'd5, 32'h2, 32'h0, 0, rd, er, lat, be, wd);
    chk("lhu2", rd, 32'h000080F0);

    // Error cases.
    do_req(1'b0, 3'd3, 32'h0, 32'h0, 0, rd, er, lat, be, wd);
    chk("err_ld011", {rd[30:0], er}, 32'h1);
    chk("err_ld011_lat", 32'(lat), 32'd1);
    do_req(1'b1, 3'd4, 32'h10, 32'h55555555, 0, rd, er, lat, be, wd);
    chk("err_st100", {rd[30:0], er}, 32'h1);
    do_req(1'b1, 3'd2, BASE + 32'h1000, 32'h12345678, 0, rd, er, lat, be, wd);
    chk("err_range", {rd[30:0], er}, 32'h1);
    chk("err_range_lat", 32'(lat), 32'd1);
    do_req(1'b1, 3'd2, 32'hFFC, 32'hA1B2C3D4, 0, rd, er, lat, be, wd);
    do_req(1'b0, 3'd2, 32'hFFC, 32'h0, 0, rd, er, lat, be, wd);
    chk("last_word", rd, 32'hA1B2C3D4);

    // Misaligned LW with a slow consumer.
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, be, wd);
    do_req(1'b0, 3'd2, 32'h12, 32'h0, 5, rd, er, lat, be, wd);
`ifdef LSU_MISALIGN_ERR_EN
    chk("mis_lw_err", 32'(er), 32'd1);
`else
    chk("mis_lw_data", rd, 32'hDEADBEEF);
    chk("mis_lw_err", 32'(er), 32'd0);
`endif

    // Reset while a store sits in ACCESS.
    do_req(1'b1, 3'd2, 32'h20, 32'h12345678, 0, rd, er, lat, be, wd);
    @(negedge clk);
    in_req_valid = 1'b1; in_req_we = 1'b1; in_req_funct3 = 3'd2;
    in_req_addr = 32'h20; in_req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    in_req_valid = 1'b0;
    chk("rst_mid_access_rw", 32'(out_mem_rw_mode), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("rst_mid_rw", {27'h0, out_mem_rw_mode, out_mem_byte_en}, 32'h0);
    chk("rst_mid_hs", {30'h0, out_resp_valid, out_req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    do_req(1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er, lat, be, wd);
    chk("rst_word_kept", rd, 32'h12345678);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      rwe   = 1'($urandom_range(0, 1));
      rf3   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) rf3 = {rwe ? 1'b0 : 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      raddr = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, 4 * WORDS - 1));
      do_req(rwe, rf3, raddr, $urandom, $urandom_range(0, 3), rd, er, lat, be, wd);
    end

    for (int i = 0; i < int'(WORDS); i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
